// File: rtl/rns_pkg.sv
// Width helpers and shared types for the RNS fold reducer.
package rns_pkg;

   localparam int unsigned RNS_TAG_W = 4;
   typedef logic [RNS_TAG_W-1:0] rns_tag_t;

   // Widths of every stage, derived once from the top-level parameters.
   typedef struct packed {
      int unsigned groups;
      int unsigned s1_w;
      int unsigned n_fold;
      int unsigned s2_w;
      int unsigned j_max;
      int unsigned res_w;
   } stage_w_t;

   function automatic int unsigned clog2_u(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   // Width after one fold of a w-bit value: low k bits plus the remaining high bits.
   function automatic int unsigned fold_bound(input int unsigned w, input int unsigned k);
      return (((w - k) > k) ? (w - k) : k) + 1;
   endfunction

   function automatic int unsigned fold_w(input int unsigned w, input int unsigned k,
                                          input int unsigned lvl);
      int unsigned r;
      r = w;
      for (int unsigned i = 0; i < lvl; i++) r = fold_bound(r, k);
      return r;
   endfunction

   // Number of folds until the value provably fits in k+1 bits.
   function automatic int unsigned fold_levels(input int unsigned w, input int unsigned k);
      int unsigned r;
      int unsigned n;
      r = w;
      n = 0;
      while (r > k + 1) begin
         r = fold_bound(r, k);
         n++;
      end
      return n;
   endfunction

   function automatic stage_w_t stage_widths(input int unsigned width, input int unsigned k,
                                             input int unsigned m);
      stage_w_t sw;
      sw.groups = ceil_div(width, k);
      sw.s1_w   = k + clog2_u(sw.groups);
      sw.n_fold = fold_levels(sw.s1_w, k);
      sw.s2_w   = k + 1;
      sw.j_max  = (m < 2) ? 0 : ((32'(1) << (k + 1)) - 1) / m;
      sw.res_w  = clog2_u(m);
      return sw;
   endfunction

endpackage

// File: rtl/rns_fold_stage.sv
// One combinational fold level: low FOLD_K bits plus the bits above them.
module rns_fold_stage
   import rns_pkg::*;
#(
   parameter int unsigned IN_W   = 9,
   parameter int unsigned FOLD_K = 6
) (
   input  logic [IN_W-1:0]                      a,
   output logic [fold_bound(IN_W, FOLD_K)-1:0]  y
);

   localparam int unsigned OUT_W = fold_bound(IN_W, FOLD_K);

   // 2^K == 1 mod M, so adding the high part to the low group preserves the residue
   assign y = OUT_W'(a[FOLD_K-1:0]) + OUT_W'(a[IN_W-1:FOLD_K]);

endmodule

// File: rtl/rns_fold_reducer_pipe.sv
// Three-stage streaming x mod MOD reducer (MOD divides 2^FOLD_K-1) with tag passthrough.
// Optional completed-transfer counter stat_cnt under RNS_FOLD_STATS_EN.
module rns_fold_reducer_pipe
   import rns_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned MOD    = 21,
   parameter int unsigned FOLD_K = 6,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(MOD)-1:0]  out_res,
   output logic [TAG_W-1:0]        out_tag
`ifdef RNS_FOLD_STATS_EN
   ,
   output logic [31:0]             stat_cnt
`endif
);

   localparam stage_w_t SW = stage_widths(WIDTH, FOLD_K, MOD);
   localparam int unsigned G     = SW.groups;
   localparam int unsigned S1_W  = SW.s1_w;
   localparam int unsigned NF    = SW.n_fold;
   localparam int unsigned S2_W  = SW.s2_w;
   localparam int unsigned J     = SW.j_max;
   localparam int unsigned RES_W = SW.res_w;
   localparam int unsigned PAD_W = G * FOLD_K;

   if ((MOD < 2) || (FOLD_K < 2) || ((((32'(1) << FOLD_K) - 1) % MOD) != 0)) begin : g_bad_cfg
      $fatal(1, "rns_fold_reducer_pipe: need MOD>=2, FOLD_K>=2 and MOD dividing 2^FOLD_K-1");
   end

   logic              stall;
   logic [PAD_W-1:0]  padded;
   logic [S1_W-1:0]   s1_d, s1_q;
   logic [S2_W-1:0]   s2_d, s2_q, sub;
   logic [RES_W-1:0]  res_d;
   logic              v1_q, v2_q;
   logic [TAG_W-1:0]  t1_q, t2_q;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Stage 1 input: sum of the zero-padded K-bit groups
   always_comb begin
      padded = PAD_W'(in_data);
      s1_d   = '0;
      for (int unsigned g = 0; g < G; g++) s1_d = s1_d + S1_W'(padded[g*FOLD_K +: FOLD_K]);
   end

   // Stage 2 input: chain of folds until the value fits in FOLD_K+1 bits
   for (genvar i = 0; i < NF; i++) begin : g_fold
      localparam int unsigned IW = fold_w(S1_W, FOLD_K, i);
      localparam int unsigned OW = fold_w(S1_W, FOLD_K, i + 1);
      logic [IW-1:0] a;
      logic [OW-1:0] y;
      if (i == 0) begin : g_first
         assign a = s1_q;
      end else begin : g_next
         assign a = g_fold[i-1].y;
      end
      rns_fold_stage #(.IN_W(IW), .FOLD_K(FOLD_K)) u_fold (.a(a), .y(y));
   end

   if (NF == 0) begin : g_nofold
      assign s2_d = S2_W'(s1_q);
   end else begin : g_last
      assign s2_d = S2_W'(g_fold[NF-1].y);
   end

   // Stage 3 input: subtract the largest multiple of MOD not exceeding s2
   always_comb begin
      sub = '0;
      for (int unsigned j = 1; j <= J; j++) begin
         if (32'(s2_q) >= j * MOD) sub = S2_W'(j * MOD);
      end
      res_d = RES_W'(s2_q - sub);
   end

   // Pipeline registers; the whole pipe holds while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         s1_q      <= '0;
         t1_q      <= '0;
         v2_q      <= 1'b0;
         s2_q      <= '0;
         t2_q      <= '0;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_tag   <= '0;
      end else if (!stall) begin
         v1_q      <= in_valid & in_ready;
         s1_q      <= s1_d;
         t1_q      <= in_tag;
         v2_q      <= v1_q;
         s2_q      <= s2_d;
         t2_q      <= t1_q;
         out_valid <= v2_q;
         out_res   <= res_d;
         out_tag   <= t2_q;
      end
   end

`ifdef RNS_FOLD_STATS_EN
   // Count completed output transfers; wraps at 2^32
   always_ff @(posedge clk) begin
      if (rst)                         stat_cnt <= '0;
      else if (out_valid & out_ready)  stat_cnt <= stat_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_rns_fold_reducer_pipe.sv
// Scoreboard bench for rns_fold_reducer_pipe: default config plus a MOD=7/K=3/W=16 instance.
module tb_rns_fold_reducer_pipe;

   localparam int W = 32, M = 21, K = 6, TW = 4, RW = 5;
   localparam int W7 = 16, M7 = 7, K7 = 3, RW7 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]   in_data;
   logic [TW-1:0]  in_tag, out_tag;
   logic [RW-1:0]  out_res;

   logic           in_valid7, in_ready7, out_valid7, out_ready7;
   logic [W7-1:0]  in_data7;
   logic [TW-1:0]  in_tag7, out_tag7;
   logic [RW7-1:0] out_res7;

`ifdef RNS_FOLD_STATS_EN
   logic [31:0] stat_cnt, stat_cnt7;
`endif

   rns_fold_reducer_pipe #(.WIDTH(W), .MOD(M), .FOLD_K(K), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_tag(out_tag)
`ifdef RNS_FOLD_STATS_EN
      , .stat_cnt(stat_cnt)
`endif
   );

   rns_fold_reducer_pipe #(.WIDTH(W7), .MOD(M7), .FOLD_K(K7), .TAG_W(TW)) dut7 (
      .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7), .in_data(in_data7),
      .in_tag(in_tag7), .out_valid(out_valid7), .out_ready(out_ready7), .out_res(out_res7),
      .out_tag(out_tag7)
`ifdef RNS_FOLD_STATS_EN
      , .stat_cnt(stat_cnt7)
`endif
   );

   typedef struct {
      logic [RW-1:0] res;
      logic [TW-1:0] tag;
      int            acc;
      bit            lat;
   } exp_t;

   typedef struct {
      logic [RW7-1:0] res;
      logic [TW-1:0]  tag;
   } exp7_t;

   exp_t  q[$];
   exp7_t q7[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Main monitor: hold stability while stalled, pop and compare on each transfer
   logic          pv;
   logic [RW-1:0] pr;
   logic [TW-1:0] pt;
   initial begin
      exp_t e;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1) begin
            if (pv) begin
               check("hold_res", 64'(out_res), 64'(pr));
               check("hold_tag", 64'(out_tag), 64'(pt));
            end
            if (out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got res=%0d tag=%0d expected no output", out_res, out_tag);
               end else begin
                  e = q.pop_front();
                  check("res", 64'(out_res), 64'(e.res));
                  check("tag", 64'(out_tag), 64'(e.tag));
                  if (e.lat) check("latency", 64'(cyc - e.acc), 64'(3));
               end
            end
         end
         pv = (out_valid === 1'b1) && !out_ready;
         pr = out_res;
         pt = out_tag;
      end
   end

   // Monitor for the MOD=7 instance (never stalled)
   initial begin
      exp7_t e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid7 === 1'b1) begin
            if (q7.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out7: got res=%0d expected no output", out_res7);
            end else begin
               e = q7.pop_front();
               check("res7", 64'(out_res7), 64'(e.res));
               check("tag7", 64'(out_tag7), 64'(e.tag));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input logic [RW-1:0] r,
                       input bit lat);
      in_valid = 1'b1;
      in_data  = d;
      in_tag   = t;
      for (int b = 0; b < 50; b++) begin
         #1;
         if (in_ready) begin
            q.push_back('{res: r, tag: t, acc: cyc, lat: lat});
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance of %0h", d);
   endtask

   // Random stream with out_ready low for cycles [s0, s0+sl)
   task automatic stream(input int n, input int s0, input int sl);
      int idx;
      logic [W-1:0] d;
      idx = 0;
      d = $urandom;
      for (int c = 0; c < 200 && idx < n; c++) begin
         out_ready = !(c >= s0 && c < s0 + sl);
         in_valid  = 1'b1;
         in_data   = d;
         in_tag    = TW'(idx);
         #1;
         if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
         else                         check("in_ready_free", 64'(in_ready), 64'(1));
         if (in_ready) begin
            q.push_back('{res: RW'(d % M), tag: TW'(idx), acc: cyc, lat: 1'b0});
            idx++;
            d = $urandom;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_accepted", 64'(idx), 64'(n));
   endtask

   task automatic drain();
      for (int b = 0; b < 100 && q.size() != 0; b++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain", 64'(q.size()), 64'(0));
   endtask

   task automatic drain7();
      for (int b = 0; b < 100 && q7.size() != 0; b++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain7", 64'(q7.size()), 64'(0));
   endtask

   task automatic send7(input logic [W7-1:0] d, input logic [TW-1:0] t, input logic [RW7-1:0] r);
      in_valid7 = 1'b1;
      in_data7  = d;
      in_tag7   = t;
      #1;
      if (in_ready7) q7.push_back('{res: r, tag: t});
      else check("in_ready7", 64'(in_ready7), 64'(1));
      @(negedge clk);
   endtask

   initial begin
      logic [W7-1:0] d7;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
      in_valid7 = 1'b0; in_data7 = '0; in_tag7 = '0; out_ready7 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_res", 64'(out_res), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);

      // Single operand, latency measured
      send(32'hFFFF_FFFF, 4'd5, 5'd3, 1'b1);
      in_valid = 1'b0;
      drain();

      // Back-to-back directed vectors with hand-computed residues
      send(32'd21,         4'd1, 5'd0,  1'b1);
      send(32'd20,         4'd2, 5'd20, 1'b1);
      send(32'd0,          4'd3, 5'd0,  1'b1);
      send(32'd63,         4'd6, 5'd0,  1'b1);
      send(32'h7FFF_FFFF,  4'd7, 5'd1,  1'b1);
      send(32'h8000_0000,  4'd9, 5'd2,  1'b1);
      send(32'd21000,      4'd8, 5'd0,  1'b1);
      send(32'd1000,       4'd4, 5'd13, 1'b1);
      in_valid = 1'b0;
      drain();

      // Random stream with a 4-cycle output stall
      stream(10, 5, 4);
      drain();

      // Reset with three operands in flight: none may come out
      out_ready = 1'b0;
      send(32'd22, 4'd1, 5'd1, 1'b0);
      send(32'd23, 4'd2, 5'd2, 1'b0);
      send(32'd24, 4'd3, 5'd3, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_out_res", 64'(out_res), 64'(0));
      check("midrst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("postrst_out_valid", 64'(out_valid), 64'(0));
      check("postrst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);

      // Six transfers with one stall cycle
      stream(6, 3, 1);
      drain();
`ifdef RNS_FOLD_STATS_EN
      repeat (3) @(negedge clk);
      #1;
      check("stat_cnt", 64'(stat_cnt), 64'(6));
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("stat_cnt_rst", 64'(stat_cnt), 64'(0));
      rst = 1'b0;
      @(negedge clk);
`endif

      // Second instance: modulus 7, 3-bit groups, 16-bit operand
      send7(16'd100,    4'd1, 3'd2);
      send7(16'hFFFF,   4'd2, 3'd1);
      send7(16'd0,      4'd3, 3'd0);
      send7(16'd8638,   4'd4, 3'd0);
      send7(16'd6,      4'd5, 3'd6);
      for (int i = 0; i < 10000; i++) begin
         d7 = 16'($urandom_range(0, 65535));
         send7(d7, TW'(i), RW7'(d7 % M7));
      end
      in_valid7 = 1'b0;
      drain7();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
